rr_sel_mux_reg: RTL and testbench

//  Parametrised N-to-1 data selector with a registered, valid/ready handshaked output.

---
 rtl/rr_sel_mux_reg_pkg.sv | 14 +
 rtl/rr_sel_mux_reg_if.sv | 27 ++
 rtl/rr_sel_mux_reg_pick.sv | 26 ++
 rtl/rr_sel_mux_reg.sv | 112 +++++++++++
 tb/tb_rr_sel_mux_reg.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/rr_sel_mux_reg_pkg.sv
// Shared types and constants for the round-robin / direct selector with registered output.
package rr_sel_mux_reg_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  localparam int XFER_W = 16;

endpackage

// File: rtl/rr_sel_mux_reg_if.sv
// Handshake bundle between the channel sources, the selector and the writeback stage.
interface rr_sel_mux_reg_if #(
  parameter int WIDTH = 32,
  parameter int N     = 16,
  parameter int SELW  = 4
);
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [SELW-1:0]    sel;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_chan;
  logic               out_valid;
  logic               out_ready;
  logic [15:0]        xfer_cnt;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid, xfer_cnt
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid, xfer_cnt
  );
endinterface

// File: rtl/rr_sel_mux_reg_pick.sv
// Rotating priority encoder: first set request after ptr, wrapping modulo N.
module rr_sel_mux_reg_pick #(
  parameter int N    = 16,
  parameter int SELW = 4
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            found,
  output logic [SELW-1:0] idx
);

  // Offset 1 is the highest priority, offset N (ptr itself) the lowest.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        idx   = SELW'((int'(ptr) + i) % N);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/rr_sel_mux_reg.sv
// N-to-1 selector (direct or round-robin) feeding a one-entry valid/ready output register.
module rr_sel_mux_reg
  import rr_sel_mux_reg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 16,
  parameter int SELW  = 4
) (
  input logic              clk,
  input logic              reset_n,
  rr_sel_mux_reg_if.slave  bus
);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0]     out_chan_q, out_chan_d;
  logic [SELW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [XFER_W-1:0]   xfer_cnt_q, xfer_cnt_d;

  logic                can_load_s;
  logic                dir_hit_s;
  logic                rr_found_s;
  logic [SELW-1:0]     rr_idx_s;
  logic                grant_found_s;
  logic [SELW-1:0]     grant_idx_s;
  logic [WIDTH-1:0]    grant_data_s;
  logic                load_s;
  logic                xfer_s;
  logic [N-1:0]        in_ready_s;

  rr_sel_mux_reg_pick #(.N(N), .SELW(SELW)) u_pick (
    .req   (bus.in_valid),
    .ptr   (rr_ptr_q),
    .found (rr_found_s),
    .idx   (rr_idx_s)
  );

  // Grant decision; reset forces no grant so nothing is taken while the block is held.
  always_comb begin
    can_load_s    = reset_n && ((state_q == ST_EMPTY) || bus.out_ready);
    dir_hit_s     = 1'b0;
    grant_data_s  = '0;
    in_ready_s    = '0;
    for (int k = 0; k < N; k++) begin
      if (bus.sel == SELW'(k)) begin
        dir_hit_s = bus.in_valid[k];
      end else begin
        dir_hit_s = dir_hit_s;
      end
    end
    if (bus.mode == MODE_RR) begin
      grant_found_s = rr_found_s;
      grant_idx_s   = rr_idx_s;
    end else begin
      grant_found_s = dir_hit_s;
      grant_idx_s   = bus.sel;
    end
    load_s = can_load_s && grant_found_s;
    for (int k = 0; k < N; k++) begin
      if (grant_idx_s == SELW'(k)) begin
        grant_data_s  = bus.in_data[k*WIDTH +: WIDTH];
        in_ready_s[k] = load_s;
      end else begin
        in_ready_s[k] = 1'b0;
      end
    end
  end

  // Next state of the output register, pointer and transfer counter.
  always_comb begin
    xfer_s     = (state_q == ST_FULL) && bus.out_ready;
    state_d    = state_q;
    out_data_d = out_data_q;
    out_chan_d = out_chan_q;
    rr_ptr_d   = rr_ptr_q;
    if (load_s) begin
      state_d    = ST_FULL;
      out_data_d = grant_data_s;
      out_chan_d = grant_idx_s;
      rr_ptr_d   = grant_idx_s;
    end else if (xfer_s) begin
      state_d = ST_EMPTY;
    end else begin
      state_d = state_q;
    end
    xfer_cnt_d = xfer_cnt_q + {{(XFER_W-1){1'b0}}, xfer_s};
  end

  // Output register FSM and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_EMPTY;
      out_data_q <= '0;
      out_chan_q <= '0;
      rr_ptr_q   <= SELW'(N-1);
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
      rr_ptr_q   <= rr_ptr_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_rr_sel_mux_reg.sv
// Directed bench for rr_sel_mux_reg: a 16-channel and a 12-channel build.
module tb_rr_sel_mux_reg;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  rr_sel_mux_reg_if #(.WIDTH(32), .N(16), .SELW(4)) bus0 ();
  rr_sel_mux_reg_if #(.WIDTH(32), .N(12), .SELW(4)) bus1 ();

  rr_sel_mux_reg #(.WIDTH(32), .N(16), .SELW(4)) u0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  rr_sel_mux_reg #(.WIDTH(32), .N(12), .SELW(4)) u1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    int exp_chan[4];
    total = 0;
    bad   = 0;
    reset_n = 1'b1;
    for (int k = 0; k < 16; k++) bus0.in_data[k*32 +: 32] = k * 32'h1111_1111;
    for (int k = 0; k < 12; k++) bus1.in_data[k*32 +: 32] = k * 32'h0101_0101;
    bus0.in_valid = 16'h0000;  bus0.mode = 1'b0; bus0.sel = 4'd0;  bus0.out_ready = 1'b1;
    bus1.in_valid = 12'hFFF;   bus1.mode = 1'b0; bus1.sel = 4'd13; bus1.out_ready = 1'b1;
    #1 reset_n = 1'b0;
    cyc(); cyc();
    chk("rst_valid", {31'd0, bus0.out_valid}, 32'd0);
    chk("rst_data",  bus0.out_data, 32'd0);
    chk("rst_cnt",   {16'd0, bus0.xfer_cnt}, 32'd0);
    chk("rst_ready", {16'd0, bus0.in_ready}, 32'd0);
    reset_n = 1'b1;

    // 12-channel build: out-of-range select never grants.
    #1 chk("n12_sel13_rdy", {20'd0, bus1.in_ready}, 32'd0);
    cyc(); chk("n12_sel13_v", {31'd0, bus1.out_valid}, 32'd0);
    cyc(); chk("n12_sel13_v2", {31'd0, bus1.out_valid}, 32'd0);
    bus1.sel = 4'd11;
    #1 chk("n12_sel11_rdy", {20'd0, bus1.in_ready}, 32'h800);
    cyc();
    chk("n12_sel11_chan", {28'd0, bus1.out_chan}, 32'd11);
    chk("n12_sel11_data", bus1.out_data, 32'h0B0B_0B0B);
    bus1.sel = 4'd12;
    cyc(); chk("n12_sel12_v", {31'd0, bus1.out_valid}, 32'd0);
    chk("n12_cnt", {16'd0, bus1.xfer_cnt}, 32'd1);

    // Direct sweep over all 16 channels.
    bus0.in_valid = 16'hFFFF;
    for (int k = 0; k < 16; k++) begin
      bus0.sel = 4'(k);
      #1 chk("dir_rdy", {16'd0, bus0.in_ready}, 32'd1 << k);
      cyc();
      chk("dir_chan", {28'd0, bus0.out_chan}, k);
      chk("dir_data", bus0.out_data, k * 32'h1111_1111);
      chk("dir_valid", {31'd0, bus0.out_valid}, 32'd1);
    end
    chk("dir_cnt", {16'd0, bus0.xfer_cnt}, 32'd15);

    // Backpressure holds the word and the counter.
    bus0.out_ready = 1'b0;
    bus0.sel = 4'd3;
    #1 chk("bp_rdy", {16'd0, bus0.in_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_chan", {28'd0, bus0.out_chan}, 32'd15);
      chk("bp_data", bus0.out_data, 32'hFFFF_FFFF);
      chk("bp_cnt", {16'd0, bus0.xfer_cnt}, 32'd15);
    end
    bus0.out_ready = 1'b1;
    #1 chk("rel_rdy", {16'd0, bus0.in_ready}, 32'h0008);
    cyc();
    chk("rel_chan", {28'd0, bus0.out_chan}, 32'd3);
    chk("rel_valid", {31'd0, bus0.out_valid}, 32'd1);
    chk("rel_cnt", {16'd0, bus0.xfer_cnt}, 32'd16);

    bus0.sel = 4'hF;
    #1 chk("sel15_rdy", {16'd0, bus0.in_ready}, 32'h8000);
    cyc();
    chk("sel15_chan", {28'd0, bus0.out_chan}, 32'd15);
    chk("sel15_cnt", {16'd0, bus0.xfer_cnt}, 32'd17);

    // Round-robin over all channels resumes after the last direct grant (15).
    bus0.mode = 1'b1;
    for (int i = 0; i < 17; i++) begin
      cyc();
      chk("rr_chan", {28'd0, bus0.out_chan}, i % 16);
    end
    chk("rr_cnt", {16'd0, bus0.xfer_cnt}, 32'd34);

    // Sparse round-robin from pointer 8.
    bus0.mode = 1'b0; bus0.sel = 4'd8; bus0.in_valid = 16'h8101;
    cyc(); chk("sp_seed", {28'd0, bus0.out_chan}, 32'd8);
    bus0.mode = 1'b1;
    exp_chan = '{15, 0, 8, 15};
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("sp_chan", {28'd0, bus0.out_chan}, exp_chan[i]);
    end
    chk("sp_cnt", {16'd0, bus0.xfer_cnt}, 32'd39);

    // Direct select of an idle channel drains the register.
    bus0.mode = 1'b0; bus0.sel = 4'd1;
    #1 chk("idle_rdy", {16'd0, bus0.in_ready}, 32'd0);
    cyc();
    chk("idle_valid", {31'd0, bus0.out_valid}, 32'd0);
    chk("idle_cnt", {16'd0, bus0.xfer_cnt}, 32'd40);

    // Asynchronous reset while FULL and stalled.
    bus0.in_valid = 16'hFFFF; bus0.sel = 4'd5; bus0.out_ready = 1'b0;
    cyc(); chk("pre_rst_valid", {31'd0, bus0.out_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, bus0.out_valid}, 32'd0);
    chk("arst_data", bus0.out_data, 32'd0);
    chk("arst_cnt", {16'd0, bus0.xfer_cnt}, 32'd0);
    chk("arst_rdy", {16'd0, bus0.in_ready}, 32'd0);
    cyc();
    reset_n = 1'b1;

    // Counter wrap: one transfer per cycle after the first load.
    bus0.mode = 1'b1; bus0.out_ready = 1'b1;
    #1 chk("wrap_first", {16'd0, bus0.in_ready}, 32'h0001);
    cyc();
    repeat (65535) cyc();
    chk("wrap_ffff", {16'd0, bus0.xfer_cnt}, 32'h0000_FFFF);
    cyc();
    chk("wrap_zero", {16'd0, bus0.xfer_cnt}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
